// File: rtl/ads111x_sample_avg_if.sv
// Stream bundle between the ADS111x reader, the averaging stage and its consumer.
// The averager takes the slave side: it receives raw samples and sources averaged results.
interface ads111x_sample_avg_if;
    logic        s_valid;
    logic [15:0] s_data;
    logic [1:0]  s_chan;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [1:0]  m_chan;
    logic        m_sat;

    modport slave (
        input  s_valid, s_data, s_chan, m_ready,
        output m_valid, m_data, m_chan, m_sat
    );

    modport master (
        output s_valid, s_data, s_chan, m_ready,
        input  m_valid, m_data, m_chan, m_sat
    );
endinterface

// File: rtl/ads111x_sample_avg.sv
// Per-channel boxcar averager for raw ADS111x conversion words.
// Produces a rounded average per window into a single-entry output register.
module ads111x_sample_avg #(
    parameter int unsigned AVG_LOG2 = 3,
    parameter int unsigned DROP_W   = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                clr,
    ads111x_sample_avg_if.slave bus,
    output logic                overrun,
    output logic [DROP_W-1:0]   drop_cnt
);
    localparam int unsigned ACC_W = 16 + AVG_LOG2;
    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic signed [SUM_W-1:0] RND = SUM_W'((1 << AVG_LOG2) >> 1);

    logic signed [ACC_W-1:0] acc_q [4];
    logic signed [ACC_W-1:0] acc_d [4];
    logic [CNT_W-1:0]        cnt_q [4];
    logic [CNT_W-1:0]        cnt_d [4];
    logic [3:0]              sat_q, sat_d;
    logic                    m_valid_q, m_valid_d;
    logic [15:0]             m_data_q, m_data_d;
    logic [1:0]              m_chan_q, m_chan_d;
    logic                    m_sat_q, m_sat_d;
    logic                    overrun_q, overrun_d;
    logic [DROP_W-1:0]       drop_cnt_q, drop_cnt_d;

    logic                    accept, full_scale, complete, pop;
    logic signed [SUM_W-1:0] sum, avg_full;
    logic                    unused_avg_hi;

    assign accept     = bus.s_valid && !clr;
    assign full_scale = (bus.s_data == 16'h7FFF) || (bus.s_data == 16'h8000);
    assign complete   = accept && (cnt_q[bus.s_chan] == CNT_LAST);
    assign pop        = m_valid_q && bus.m_ready;
    assign sum        = SUM_W'(acc_q[bus.s_chan]) + SUM_W'(signed'(bus.s_data));
    assign avg_full   = (sum + RND) >>> AVG_LOG2;
    // Upper bits only repeat the sign: a window average always fits 16 bits.
    assign unused_avg_hi = ^avg_full[SUM_W-1:16];

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_chan_d   = m_chan_q;
        m_sat_d    = m_sat_q;
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;

        if (clr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                acc_d[i] = '0;
                cnt_d[i] = '0;
            end
            sat_d      = '0;
            overrun_d  = 1'b0;
            drop_cnt_d = '0;
        end else if (accept) begin
            if (complete) begin
                acc_d[bus.s_chan] = '0;
                cnt_d[bus.s_chan] = '0;
                sat_d[bus.s_chan] = 1'b0;
            end else begin
                acc_d[bus.s_chan] = acc_q[bus.s_chan] + ACC_W'(signed'(bus.s_data));
                cnt_d[bus.s_chan] = cnt_q[bus.s_chan] + 1'b1;
                sat_d[bus.s_chan] = sat_q[bus.s_chan] | full_scale;
            end
        end

        if (pop) begin
            m_valid_d = 1'b0;
        end

        // A pop in the same cycle frees the register, so the new result loads without a drop.
        if (complete) begin
            if (!m_valid_q || pop) begin
                m_valid_d = 1'b1;
                m_data_d  = avg_full[15:0];
                m_chan_d  = bus.s_chan;
                m_sat_d   = sat_q[bus.s_chan] | full_scale;
            end else begin
                overrun_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                acc_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            sat_q      <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_chan_q   <= '0;
            m_sat_q    <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_chan_q   <= m_chan_d;
            m_sat_q    <= m_sat_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_chan  = m_chan_q;
    assign bus.m_sat   = m_sat_q;
    assign overrun     = overrun_q;
    assign drop_cnt    = drop_cnt_q;
endmodule

// File: doc/ads111x_sample_avg.md
Name: ads111x_sample_avg

Overview:
- Downstream stage of the ADS111x I2C reader. It consumes raw 16-bit signed conversion words, each tagged with its MUX channel (0-3).
- Keeps a boxcar average per channel over 2^AVG_LOG2 samples, rounds it, and presents one averaged word per completed window on a valid/ready output.
- Flags full-scale samples and counts results dropped under output backpressure.

Parameters:
- AVG_LOG2, 3: log2 of window length per channel; legal range 0..6 (0 = pass-through, still registered).
- DROP_W, 8: width of the saturating dropped-result counter.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear of accumulators, counts, overrun and drop_cnt.
- s_valid  input  1  raw sample strobe; accepted every cycle it is high (no input backpressure).
- s_data  input  16  raw ADS111x conversion word, two's complement.
- s_chan  input  2  MUX channel of s_data.
- m_valid  output  1  averaged result available.
- m_ready  input  1  consumer accepts result when m_valid & m_ready.
- m_data  output  16  rounded average, two's complement.
- m_chan  output  2  channel of m_data.
- m_sat  output  1  at least one sample in the window was 16'h7FFF or 16'h8000.
- overrun  output  1  sticky: a result was dropped; cleared only by clr or reset.
- drop_cnt  output  DROP_W  number of dropped results, saturating at all-ones.

Behaviour:
- Reset (async, sys_rst=1): all accumulators, per-channel counts and sat bits = 0; m_valid=0, m_data=0, m_chan=0, m_sat=0, overrun=0, drop_cnt=0. Reset mid-window discards the partial window.
- Per channel c: acc[c] signed 16+AVG_LOG2 bits, cnt[c] AVG_LOG2 bits, sat[c] 1 bit.
- Accepted sample (s_valid=1, clr=0), when cnt[c] != 2^AVG_LOG2-1:
  - acc[c] += sign-extended s_data
  - cnt[c] += 1
  - sat[c] |= full-scale(s_data)
- Accepted sample when cnt[c] == 2^AVG_LOG2-1 (window completes):
  - sum = acc[c] + s_data.
  - result = (sum + 2^(AVG_LOG2-1)) >>> AVG_LOG2, arithmetic, i.e. round half toward +inf. For AVG_LOG2=0, result = s_data.
  - The intermediate is 17+AVG_LOG2 bits; the result always fits 16 bits, so no clipping.
  - acc[c], cnt[c] and sat[c] reset to 0 in the same cycle.
- Latency: result is registered. m_valid rises the cycle after the completing sample is accepted, with m_data, m_chan and m_sat = sat[c] | full-scale(s_data).
- Output register (single entry):
  - Loads a completed result if it is empty, or if m_valid & m_ready in the same cycle (simultaneous pop and load: new result loads, no drop).
  - If full and not popped, the new result is discarded: overrun <= 1, drop_cnt += 1 (saturating). The existing m_data/m_chan/m_sat hold.
  - m_data/m_chan/m_sat are stable while m_valid=1 and m_ready=0.
  - m_valid falls the cycle after m_valid & m_ready when no new result loads.
- Only one sample can be accepted per cycle, so at most one window completes per cycle.
- Channels are independent; interleaving in any order is legal.
- clr=1:
  - Zeros all acc/cnt/sat, overrun and drop_cnt.
  - A sample presented in the same cycle is discarded.
  - Output register and m_valid are unaffected; a pending result still transfers normally.
- s_chan and s_data are ignored when s_valid=0.

Test Plan:
- AVG_LOG2=3, ch0 samples 100..107 back-to-back, m_ready=1 -> one cycle after 8th sample: m_valid=1, m_data=104, m_chan=0, m_sat=0; no other output.
- Eight samples of -3 (16'hFFFD) on ch2 -> m_data=-3 (16'hFFFD); eight samples alternating -1/-2 on ch2 -> sum -12, m_data=-1 (rounding check).
- Interleave ch1 (8x 1000) and ch3 (8x -1000) sample by sample -> ch1 result 1000 completes first, then ch3 result -1000 next completion; accumulators independent.
- m_ready=0, complete ch0 window (8x 5) then ch1 window (8x 7) -> m_data stays 5/ch0, overrun=1, drop_cnt=1. Then m_ready=1 -> 5 accepted, m_valid falls; clr -> overrun=0, drop_cnt=0.
- ch0 window containing one 16'h7FFF and seven 0 -> m_sat=1, m_data=4096. Next window all 0 -> m_sat=0, m_data=0.
- Four ch0 samples of 50, then clr (with a 5th sample same cycle), then 8x 20 -> single result m_data=20; assert sys_rst mid-window -> all outputs return to reset values immediately.
